// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM encodings plus opcode classification.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_PASS = 4'd0,
    OP_NOT  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_OR   = 4'd4,
    OP_AND  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_XOR  = 4'd8,
    OP_SLL  = 4'd9,
    OP_SRL  = 4'd10,
    OP_SRA  = 4'd11,
    OP_MULU = 4'd12,
    OP_DIVU = 4'd13
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } alu_state_t;

  // Opcodes that go through the iterative engine instead of the one-cycle datapath.
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between the register-read latches and the ALU output registers.
// Latency: n/a (wires only).
// Backpressure: start is honoured only while busy is low; there is no queueing.
// Ports: master drives start/alu_op/R2/R3; slave (the ALU) drives R0/R1, flags, busy and done.
interface seq_alu_if #(
  parameter int W = 32
);
  logic         start;
  logic [3:0]   alu_op;
  logic [W-1:0] R2;
  logic [W-1:0] R3;
  logic [W-1:0] R0;
  logic [W-1:0] R1;
  logic         c_out;
  logic         zero;
  logic         ovf;
  logic         err;
  logic         busy;
  logic         done;

  modport master (
    output start, alu_op, R2, R3,
    input  R0, R1, c_out, zero, ovf, err, busy, done
  );

  modport slave (
    input  start, alu_op, R2, R3,
    output R0, R1, c_out, zero, ovf, err, busy, done
  );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-and-add) / restoring divide, one bit per cycle.
// Latency: W iterations after go; lo/hi show the result of the step in progress, final when last=1.
// Backpressure: none internally; go must only be pulsed while the engine is idle.
// Ports: clk, rst_n; go/is_div/a/b load a job; lo/hi step result; dz divisor zero; last final step.
module seq_alu_muldiv #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         dz,
  output logic         last
);
  localparam int SHW = $clog2(W);

  logic           run_q;
  logic           div_q;
  logic [SHW-1:0] cnt_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   hi_q;   // product high half / partial remainder
  logic [W-1:0]   lo_q;   // multiplier being consumed / dividend becoming quotient

  logic [W:0]     sh_s;
  logic [W:0]     add_s;
  logic [W-1:0]   diff;
  logic           ge;

  always_comb begin
    // Divide: bring the next dividend bit into the remainder and try to subtract.
    // The compare is done at W+1 bits so a zero divisor always "fits", which yields
    // an all-ones quotient and leaves the dividend as the remainder.
    sh_s  = {hi_q, lo_q[W-1]};
    ge    = (sh_s >= {1'b0, b_q});
    diff  = sh_s[W-1:0] - b_q;
    // Multiply: conditionally add the multiplicand, then shift the pair right.
    add_s = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q}) : {1'b0, hi_q};
    if (div_q) begin
      hi = ge ? diff : sh_s[W-1:0];
      lo = {lo_q[W-2:0], ge};
    end else begin
      hi = add_s[W:1];
      lo = {add_s[0], lo_q[W-1:1]};
    end
  end

  assign dz   = div_q && (b_q == '0);
  assign last = run_q && (cnt_q == SHW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (go) begin
      run_q <= 1'b1;
      div_q <= is_div;
      cnt_q <= '0;
      b_q   <= b;
      hi_q  <= '0;
      lo_q  <= a;
    end else if (run_q) begin
      hi_q <= hi;
      lo_q <= lo;
      if (last) begin
        run_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + SHW'(1);
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: one-cycle logic/arith/shift ops plus iterative MULU/DIVU with flags.
// Latency: 1 cycle for single-cycle ops, W+1 cycles for MULU/DIVU; done pulses one cycle.
// Backpressure: busy high while iterating; start is ignored (not queued) until busy drops.
// Ports: clk, rst_n, and bus (slave side of seq_alu_if) carrying start/alu_op/R2/R3 in and
// R0/R1/c_out/zero/ovf/err/busy/done out.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(W);

  alu_state_t     state_q, state_d;
  logic           accept, mc, go;
  logic           done_d, load;
  logic [SHW-1:0] shamt;
  logic [W:0]     sum, dif;
  logic [W-1:0]   s_lo;
  logic           s_c, s_v, s_err;
  logic [W-1:0]   n_lo, n_hi;
  logic           n_c, n_v, n_e;
  logic [W-1:0]   md_lo, md_hi;
  logic           md_dz, md_last;

  logic [W-1:0]   r0_q, r1_q;
  logic           c_q, z_q, v_q, e_q, done_q;

  assign mc = is_multicycle(bus.alu_op);
  assign go = accept && mc;

  // Single-cycle datapath, evaluated on the live inputs at the accepting edge.
  always_comb begin
    shamt = bus.R3[SHW-1:0];
    sum   = {1'b0, bus.R2} + {1'b0, bus.R3};
    dif   = {1'b0, bus.R2} - {1'b0, bus.R3};
    s_lo  = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    s_err = 1'b0;
    case (bus.alu_op)
      OP_PASS: s_lo = bus.R2;
      OP_NOT:  s_lo = ~bus.R2;
      OP_ADD: begin
        s_lo = sum[W-1:0];
        s_c  = sum[W];
        s_v  = (bus.R2[W-1] == bus.R3[W-1]) && (sum[W-1] != bus.R2[W-1]);
      end
      OP_SUB: begin
        s_lo = dif[W-1:0];
        s_c  = dif[W];  // borrow
        s_v  = (bus.R2[W-1] != bus.R3[W-1]) && (dif[W-1] != bus.R2[W-1]);
      end
      OP_OR:   s_lo = bus.R2 | bus.R3;
      OP_AND:  s_lo = bus.R2 & bus.R3;
      OP_SLT:  s_lo = {{(W-1){1'b0}}, ($signed(bus.R2) < $signed(bus.R3))};
      OP_SLTU: s_lo = {{(W-1){1'b0}}, (bus.R2 < bus.R3)};
      OP_XOR:  s_lo = bus.R2 ^ bus.R3;
      OP_SLL:  s_lo = bus.R2 << shamt;
      OP_SRL:  s_lo = bus.R2 >> shamt;
      OP_SRA:  s_lo = $signed(bus.R2) >>> shamt;
      OP_MULU, OP_DIVU: s_lo = '0;
      default: s_err = 1'b1;  // 14/15: zero result, error flag
    endcase
  end

  // FSM next-state and output-register load selection.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    n_lo    = s_lo;
    n_hi    = '0;
    n_c     = s_c;
    n_v     = s_v;
    n_e     = s_err;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (mc) begin
            state_d = RUN;
          end else begin
            load   = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        // The engine's step output on its last iteration is the final result.
        if (md_last) begin
          state_d = IDLE;
          load    = 1'b1;
          done_d  = 1'b1;
          n_lo    = md_lo;
          n_hi    = md_hi;
          n_c     = 1'b0;
          n_v     = 1'b0;
          n_e     = md_dz;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      r0_q    <= '0;
      r1_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b1;
      v_q     <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      // Results and flags only move when an operation completes.
      if (load) begin
        r0_q <= n_lo;
        r1_q <= n_hi;
        c_q  <= n_c;
        z_q  <= (n_lo == '0);
        v_q  <= n_v;
        e_q  <= n_e;
      end
    end
  end

  seq_alu_muldiv #(.W(W)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (go),
    .is_div (bus.alu_op == OP_DIVU),
    .a      (bus.R2),
    .b      (bus.R3),
    .lo     (md_lo),
    .hi     (md_hi),
    .dz     (md_dz),
    .last   (md_last)
  );

  assign bus.R0    = r0_q;
  assign bus.R1    = r1_q;
  assign bus.c_out = c_q;
  assign bus.zero  = z_q;
  assign bus.ovf   = v_q;
  assign bus.err   = e_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked ALU for the multicycle datapath. It extends the single-cycle operation set (pass, invert, add, subtract, or, and, signed compare) with XOR, unsigned compare, barrel shifts, and iterative unsigned multiply and divide. It also adds status flags and a start/busy/done handshake, so the control FSM can stall on long operations. It sits between the register-read latches (R2/R3) and the ALUOut/HI registers.

## Interface
- `W`, default 32: operand/result width; power of two, ≥ 8.
- `SHW`, default `$clog2(W)`: shift-amount width; derived, not overridden.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `alu_op`  in  4  operation code, sampled with `start`.
- `R2`  in  W  operand A, sampled with `start`.
- `R3`  in  W  operand B, sampled with `start`.
- `R0`  out  W  result (low word).
- `R1`  out  W  high word (product high / remainder); 0 for other ops.
- `c_out`  out  1  carry (ADD) / borrow (SUB); 0 otherwise.
- `zero`  out  1  `R0`==0.
- `ovf`  out  1  signed overflow (ADD/SUB); 0 otherwise.
- `err`  out  1  illegal opcode or divide-by-zero.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse: outputs valid.

## Operation
- Opcodes:
  - 0 PASS (`R2`); 1 NOT (`~R2`); 2 ADD; 3 SUB.
  - 4 OR; 5 AND; 6 SLT signed; 7 SLTU.
  - 8 XOR; 9 SLL; 10 SRL; 11 SRA.
  - 12 MULU; 13 DIVU; 14–15 illegal.
- ADD/SUB are computed at W+1 bits: `{0,R2}±{0,R3}`. Bit W drives `c_out`. `ovf` is set when the operand signs match (ADD) or differ (SUB) and the result sign differs from `R2`.
- SLT/SLTU: `R0` = 0 or 1, zero-extended.
- Shifts: amount is `R3[SHW-1:0]`; upper bits of `R3` are ignored. SRA replicates `R2[W-1]`.
- MULU: shift-and-add, one bit per cycle, W iterations. `{R1,R0}` = full 2W-bit product.
- DIVU: restoring division, W iterations. `R0` = quotient, `R1` = remainder.
- Divide by zero: `R0` = all ones, `R1` = `R2`, `err`=1. The operation still takes the full W cycles.
- Illegal opcode: `R0`=`R1`=0 and `err`=1, completed as a single-cycle op.
- FSM states:
  - IDLE: on `start` with a single-cycle op, go to IDLE and pulse `done`. On `start` with MULU/DIVU, go to RUN.
  - RUN: iteration counter runs 0..W-1. At count W-1, go to IDLE and pulse `done`.
- `start` while `busy`=1 is ignored; there is no queueing.
- Outputs and flags hold their last value until the next accepted `start` completes.
- `zero` is computed on the final `R0` for every op.

## Timing
- Reset (async assert, synchronous release): `R0`=`R1`=0, `c_out`=`ovf`=`err`=0, `zero`=1, `busy`=`done`=0, state=IDLE, counter=0.
- Reset mid-RUN aborts the operation; no `done` is issued.
- Single-cycle op, `start` sampled at edge t: outputs are valid after edge t, and `done`=1 from edge t to edge t+1. Latency is 1, matching the registered behaviour of the existing ALU.
- MULU/DIVU, `start` sampled at edge t:
  - `busy`=1 after edge t.
  - Iterations occur at edges t+1..t+W.
  - After edge t+W: `busy`=0, `done`=1, results valid.
  - Total W+1 cycles.
- During RUN, `R0`/`R1`/flags keep the previous result. Internal accumulators are separate registers.
- A new `start` is accepted in the same cycle `done`=1, giving back-to-back throughput.
- Operands and op are latched at acceptance. Changes on `R2`/`R3`/`alu_op` during RUN have no effect.

## Structure
- Package `seq_alu_pkg`:
  - `alu_op_t` enum (4-bit, values above).
  - `alu_state_t` {IDLE, RUN}.
  - Helper function `is_multicycle(op)`.
- Sub-module `seq_alu_muldiv`:
  - Iterative multiply/divide engine, parametrised by `W`.
  - Ports: `clk`, `rst_n`, `go`, `is_div`, `a`, `b`, `lo`, `hi`, `dz`, `last`.
  - The top-level holds the FSM, single-cycle datapath, flags and output registers.

## Test plan
- W=32, ADD `0xFFFFFFFF`+1 → `R0`=0, `c_out`=1, `zero`=1, `ovf`=0, `done` one cycle after `start`. ADD `0x7FFFFFFF`+1 → `ovf`=1.
- SUB 3−5 → `R0`=`0xFFFFFFFE`, `c_out`=1. SLT(−1, 1) = 1 while SLTU(−1, 1) = 0. SRA `0x80000000` by 36 → `0xF8000000` (amount 4).
- MULU `0xFFFFFFFF`×`0xFFFFFFFF` → `R1`=`0xFFFFFFFE`, `R0`=1. `busy` high for exactly 32 cycles; `done` at cycle 33.
- DIVU 100/7 → `R0`=14, `R1`=2. DIVU 9/0 → `R0`=`0xFFFFFFFF`, `R1`=9, `err`=1.
- `start` pulsed mid-MULU with ADD → ignored; MULU result unaffected. A new `start` asserted in the `done` cycle is accepted.
- `rst_n` low at iteration 10 of DIVU → all outputs at reset values, no `done`. Opcode 15 → `err`=1, `R0`=0. Repeat the first case with W=8.
